// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: count enable in, registered raster timing out.
interface vga_timing_gen_if #(
    parameter int XW = 11,
    parameter int YW = 10
);
    logic          en;
    logic          h_sync;
    logic          v_sync;
    logic          avr;
    logic          vblank;
    logic          line_start;
    logic          frame_start;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] line_y;

    modport master (
        input  en,
        output h_sync, v_sync, avr, vblank, line_start, frame_start, pixel_x, line_y
    );

    modport slave (
        output en,
        input  h_sync, v_sync, avr, vblank, line_start, frame_start, pixel_x, line_y
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters with registered sync/blank/pulse decode, one clock behind the counters.
module vga_timing_gen #(
    parameter int H_VISIBLE = 1024,
    parameter int H_FRONT   = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BACK    = 144,
    parameter int V_VISIBLE = 768,
    parameter int V_FRONT   = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BACK    = 29,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0
) (
    input logic clk,
    input logic rst_n,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int XW = $clog2(H_TOTAL);
    localparam int YW = $clog2(V_TOTAL);
    localparam logic [XW-1:0] H_MAX  = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_VIS  = XW'(H_VISIBLE);
    localparam logic [XW-1:0] HS_BEG = XW'(H_VISIBLE + H_FRONT);
    localparam logic [XW-1:0] HS_END = XW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [YW-1:0] V_MAX  = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_VIS  = YW'(V_VISIBLE);
    localparam logic [YW-1:0] VS_BEG = YW'(V_VISIBLE + V_FRONT);
    localparam logic [YW-1:0] VS_END = YW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;

    assign h_last = h_cnt == H_MAX;
    assign v_last = v_cnt == V_MAX;

    // Outputs decode the pre-advance counter pair, so they trail h_cnt/v_cnt by exactly one enabled clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt           <= '0;
            v_cnt           <= '0;
            bus.pixel_x     <= '0;
            bus.line_y      <= '0;
            bus.avr         <= 1'b0;
            bus.vblank      <= 1'b0;
            bus.line_start  <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.h_sync      <= ~HS_POL;
            bus.v_sync      <= ~VS_POL;
        end else if (bus.en) begin
            h_cnt           <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last)
                v_cnt       <= v_last ? '0 : v_cnt + 1'b1;
            bus.pixel_x     <= h_cnt;
            bus.line_y      <= v_cnt;
            bus.avr         <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
            bus.vblank      <= v_cnt >= V_VIS;
            bus.line_start  <= h_cnt == '0;
            bus.frame_start <= (h_cnt == '0) && (v_cnt == '0);
            bus.h_sync      <= (h_cnt >= HS_BEG && h_cnt <= HS_END) ? HS_POL : ~HS_POL;
            bus.v_sync      <= (v_cnt >= VS_BEG && v_cnt <= VS_END) ? VS_POL : ~VS_POL;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a small active-high mode and the default 1024x768 mode.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   pos = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.XW(4), .YW(3)) bs();
    vga_timing_gen_if #(.XW(11), .YW(10)) bd();

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_s (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bs)
    );

    vga_timing_gen dut_d (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bd)
    );

    // Small mode: 14 clocks per line, 8 lines per frame; packing {x, y, avr, vblank, hs, vs, ls, fs}.
    function automatic logic [12:0] exp_s(input int p);
        int x = p % 14;
        int y = p / 14;
        return {4'(x), 3'(y), (x < 8) && (y < 4), y >= 4, (x >= 10) && (x <= 12),
                (y >= 5) && (y <= 6), x == 0, (x == 0) && (y == 0)};
    endfunction

    function automatic logic [12:0] got_s();
        return {bs.pixel_x, bs.line_y, bs.avr, bs.vblank, bs.h_sync, bs.v_sync,
                bs.line_start, bs.frame_start};
    endfunction

    task automatic test_reset();
        logic [26:0] gd;
        bs.en = 1'b0;
        bd.en = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (got_s() !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_small: got %b want %b", got_s(), 13'd0);
        end
        gd = {bd.pixel_x, bd.line_y, bd.avr, bd.vblank, bd.line_start, bd.frame_start, bd.h_sync, bd.v_sync};
        n_chk++;
        if (gd !== 27'b11) begin
            n_fail++;
            $display("FAIL reset_default: got %b want %b", gd, 27'b11);
        end
        bs.en = 1'b1;
        @(negedge clk);
        n_chk++;
        if (got_s() !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_overrides_en: got %b want %b", got_s(), 13'd0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_frames();
        logic [12:0] g;
        int n_ls = 0, n_av = 0, n_vb = 0, n_fs = 0;
        for (int i = 0; i < 336; i++) begin
            @(negedge clk);
            g = got_s();
            n_chk++;
            if (g !== exp_s(i % 112)) begin
                n_fail++;
                $display("FAIL frame_cycle %0d: got %b want %b", i, g, exp_s(i % 112));
            end
            n_fs += int'(g[0]);
            n_ls += int'(g[1]);
            n_vb += int'(g[4]);
            n_av += int'(g[5]);
        end
        pos = 111;
        n_chk++;
        if (n_ls != 24) begin
            n_fail++;
            $display("FAIL line_start_count: got %0d want 24", n_ls);
        end
        n_chk++;
        if (n_fs != 3) begin
            n_fail++;
            $display("FAIL frame_start_count: got %0d want 3", n_fs);
        end
        n_chk++;
        if (n_av != 96) begin
            n_fail++;
            $display("FAIL avr_count: got %0d want 96", n_av);
        end
        n_chk++;
        if (n_vb != 168) begin
            n_fail++;
            $display("FAIL vblank_count: got %0d want 168", n_vb);
        end
    endtask

    task automatic test_en_hold();
        bs.en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_chk++;
            if (got_s() !== exp_s(111)) begin
                n_fail++;
                $display("FAIL en_hold %0d: got %b want %b", k, got_s(), exp_s(111));
            end
        end
        bs.en = 1'b1;
        @(negedge clk);
        n_chk++;
        if (got_s() !== exp_s(0)) begin
            n_fail++;
            $display("FAIL en_resume: got %b want %b", got_s(), exp_s(0));
        end
        bs.en = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_chk++;
            if (got_s() !== exp_s(0)) begin
                n_fail++;
                $display("FAIL pulse_hold: got %b want %b", got_s(), exp_s(0));
            end
        end
        bs.en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_chk++;
            if (got_s() !== exp_s(k)) begin
                n_fail++;
                $display("FAIL no_skip %0d: got %b want %b", k, got_s(), exp_s(k));
            end
        end
        pos = 3;
    endtask

    task automatic test_mid_reset();
        while (pos != 81) begin
            @(negedge clk);
            pos = (pos + 1) % 112;
            n_chk++;
            if (got_s() !== exp_s(pos)) begin
                n_fail++;
                $display("FAIL approach %0d: got %b want %b", pos, got_s(), exp_s(pos));
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++;
        if (got_s() !== 13'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %b want %b", got_s(), 13'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (got_s() !== exp_s(0)) begin
            n_fail++;
            $display("FAIL after_mid_reset: got %b want %b", got_s(), exp_s(0));
        end
    endtask

    task automatic test_default();
        logic [26:0] gd, ed;
        int x, y, n_low = 0;
        bs.en = 1'b0;
        bd.en = 1'b1;
        for (int k = 0; k < 2656; k++) begin
            @(negedge clk);
            x = k % 1328;
            y = k / 1328;
            ed = {11'(x), 10'(y), (x < 1024) && (y < 768), 1'b0, x == 0, (x == 0) && (y == 0),
                  !((x >= 1048) && (x <= 1183)), 1'b1};
            gd = {bd.pixel_x, bd.line_y, bd.avr, bd.vblank, bd.line_start, bd.frame_start, bd.h_sync, bd.v_sync};
            n_chk++;
            if (gd !== ed) begin
                n_fail++;
                $display("FAIL default_cycle %0d: got %b want %b", k, gd, ed);
            end
            n_low += int'(!bd.h_sync);
        end
        n_chk++;
        if (n_low != 272) begin
            n_fail++;
            $display("FAIL default_hsync_low: got %0d want 272", n_low);
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_en_hold();
        test_mid_reset();
        test_default();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, 1024, active pixels per line, SHALL be >= 1.
REQ-002 Parameter H_FRONT, 24, horizontal front porch in clocks, SHALL be >= 1.
REQ-003 Parameter H_SYNC, 136, horizontal sync width in clocks, SHALL be >= 1.
REQ-004 Parameter H_BACK, 144, horizontal back porch in clocks, SHALL be >= 1.
REQ-005 Parameter V_VISIBLE, 768, active lines per frame, SHALL be >= 1.
REQ-006 Parameter V_FRONT, 3, vertical front porch in lines, SHALL be >= 1.
REQ-007 Parameter V_SYNC, 6, vertical sync width in lines, SHALL be >= 1.
REQ-008 Parameter V_BACK, 29, vertical back porch in lines, SHALL be >= 1.
REQ-009 Parameter HS_POL, 0, h_sync active level (1 = active-high, 0 = active-low).
REQ-010 Parameter VS_POL, 0, v_sync active level (1 = active-high, 0 = active-low).
REQ-011 Derived widths SHALL be: H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters; XW = clog2(H_TOTAL); YW = clog2(V_TOTAL).
REQ-012 clk  input  1  pixel clock, all logic on rising edge (75 MHz for the default mode).
REQ-013 rst_n  input  1  reset, synchronous, active-low.
REQ-014 en  input  1  count enable; when low, all state and outputs hold.
REQ-015 h_sync  output  1  horizontal sync at HS_POL level during the sync interval.
REQ-016 v_sync  output  1  vertical sync at VS_POL level during the sync interval.
REQ-017 avr  output  1  active video region; high only when both pixel and line are visible.
REQ-018 vblank  output  1  high for every line >= V_VISIBLE.
REQ-019 line_start  output  1  one-cycle pulse at pixel 0 of every line.
REQ-020 frame_start  output  1  one-cycle pulse at pixel 0 of line 0.
REQ-021 pixel_x  output  XW  current pixel count, 0..H_TOTAL-1.
REQ-022 line_y  output  YW  current line count, 0..V_TOTAL-1.

Function
REQ-023 Internal counters h_cnt and v_cnt SHALL advance on each enabled clock; h_cnt wraps H_TOTAL-1 -> 0.
REQ-024 v_cnt SHALL increment only on the cycle h_cnt wraps, and SHALL wrap V_TOTAL-1 -> 0 on the cycle both counters are at their maxima.
REQ-025 Line order SHALL be visible [0, H_VISIBLE-1], front porch, sync [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], back porch; vertical uses the same order in lines.
REQ-026 All outputs SHALL be registered, decoded from the current (h_cnt, v_cnt), with exactly one clock of latency, and mutually aligned.
REQ-027 pixel_x and line_y SHALL equal the (h_cnt, v_cnt) pair that avr, h_sync, v_sync, vblank, line_start and frame_start describe on the same cycle.
REQ-028 avr SHALL be 1 iff pixel_x < H_VISIBLE and line_y < V_VISIBLE.
REQ-029 h_sync SHALL depend on pixel_x only and v_sync on line_y only; v_sync SHALL change only together with line_start.
REQ-030 en low SHALL freeze counters and all outputs, including pulses, at their current values; resuming SHALL continue from the frozen position with no skipped or repeated count.
REQ-031 Arithmetic SHALL be unsigned and exact at XW/YW bits; no counter value >= H_TOTAL or >= V_TOTAL SHALL ever occur.

Reset
REQ-032 While rst_n is low at a clock edge, h_cnt and v_cnt SHALL become 0.
REQ-033 While rst_n is low at a clock edge, the outputs SHALL become: pixel_x = 0, line_y = 0, avr = 0, vblank = 0, line_start = 0, frame_start = 0, h_sync = ~HS_POL, v_sync = ~VS_POL.
REQ-034 rst_n SHALL override en; a mid-frame reset SHALL abandon the frame with no partial sync pulse beyond the reset edge.
REQ-035 On the first enabled edge after reset release, the outputs SHALL show (0,0): avr = 1, line_start = 1, frame_start = 1.

Verification
REQ-036 Defaults, rst_n released with en = 1 -> frame_start period 1328 × 806 = 1,070,368 clocks; h_sync low for 136 clocks at pixel_x 1048..1183; v_sync low for 6 lines at line_y 771..776.
REQ-037 Small config H 8/2/3/1, V 4/1/2/1, HS_POL = VS_POL = 1 -> line 14 clocks, frame 112 clocks; avr count 32 per frame; h_sync high at pixel_x 10..12.
REQ-038 Small config, en dropped for 5 cycles at pixel_x = 13, line_y = 7 -> outputs hold 5 cycles; next advance gives (0,0) with frame_start = 1.
REQ-039 Small config, rst_n low for 1 cycle at pixel_x = 11, line_y = 5 -> h_sync and v_sync inactive, avr = 0 during reset; next cycle (0,0), avr = 1.
REQ-040 Any config, run 3 frames -> line_start pulses = 3 × V_TOTAL; vblank high for exactly (V_TOTAL - V_VISIBLE) × H_TOTAL clocks per frame.
